// File: rtl/regfile_port_decoder_pkg.sv
// rtl/regfile_port_decoder_pkg.sv - shared constants and types for the register file port decoder
package regfile_port_decoder_pkg;

    // Default geometry of the register file
    localparam int REG_ADDR_W = 4;
    localparam int REG_DEPTH  = 16;
    localparam int REG_NUM_RD = 2;

    typedef logic [REG_ADDR_W-1:0] reg_id_t;

    // Register id that becomes the hardwired zero register when that feature is built in
    localparam reg_id_t ZERO_REG_ID = reg_id_t'(0);

endpackage

// File: rtl/regfile_port_decoder_onehot_decoder.sv
// rtl/regfile_port_decoder_onehot_decoder.sv - combinational enable-gated id to one-hot wordline decoder
module regfile_port_decoder_onehot_decoder #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_id,
    input  logic              i_zero_suppress,
    output logic [DEPTH-1:0]  o_onehot
);

    logic w_suppress;

    // Id 0 produces no wordline when the caller treats it as a hardwired zero register
    assign w_suppress = i_zero_suppress & (i_id == '0);

    // Drive exactly one wordline for an enabled, non-suppressed request
    always_comb begin
        o_onehot = '0;
        if (i_en && !w_suppress) begin
            o_onehot[i_id] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_port_decoder.sv
// rtl/regfile_port_decoder.sv - registered read/write wordline decoder with busy scoreboard; option REG_ZERO_HARDWIRE_EN
module regfile_port_decoder
    import regfile_port_decoder_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = REG_DEPTH,
    parameter int NUM_RD = REG_NUM_RD
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_RD-1:0]        i_rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_id,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_id,
    input  logic                     i_rsv_en,
    input  logic [ADDR_W-1:0]        i_rsv_id,
    output logic [NUM_RD*DEPTH-1:0]  o_rd_wordline,
    output logic [DEPTH-1:0]         o_wr_wordline,
    output logic [NUM_RD-1:0]        o_rd_bypass,
    output logic [NUM_RD-1:0]        o_rd_stall,
    output logic [DEPTH-1:0]         o_busy_vec
);

`ifdef REG_ZERO_HARDWIRE_EN
    localparam logic ZERO_HW = 1'b1;
`else
    localparam logic ZERO_HW = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ZERO_ID = ADDR_W'(ZERO_REG_ID);

    // Ids are not range-checked at run time, so every id must map onto a real register
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("regfile_port_decoder: DEPTH must equal 2**ADDR_W");
    end

    logic [ADDR_W-1:0]        w_rd_id [NUM_RD];
    logic [NUM_RD*DEPTH-1:0]  w_rd_onehot;
    logic [DEPTH-1:0]         w_wr_onehot;
    logic [NUM_RD-1:0]        w_rd_hit;
    logic [NUM_RD-1:0]        w_rd_zero;
    logic [NUM_RD-1:0]        w_bypass;
    logic [NUM_RD-1:0]        w_stall;
    logic                     w_rsv_zero;
    logic [DEPTH-1:0]         w_busy_next;

    logic [NUM_RD*DEPTH-1:0]  r_rd_wordline;
    logic [DEPTH-1:0]         r_wr_wordline;
    logic [NUM_RD-1:0]        r_rd_bypass;
    logic [NUM_RD-1:0]        r_rd_stall;
    logic [DEPTH-1:0]         r_busy;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
        assign w_rd_id[p] = i_rd_id[p*ADDR_W +: ADDR_W];

        regfile_port_decoder_onehot_decoder #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_rd_dec (
            .i_en            (i_rd_en[p]),
            .i_id            (w_rd_id[p]),
            .i_zero_suppress (ZERO_HW),
            .o_onehot        (w_rd_onehot[p*DEPTH +: DEPTH])
        );
    end

    regfile_port_decoder_onehot_decoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_wr_dec (
        .i_en            (i_wr_en),
        .i_id            (i_wr_id),
        .i_zero_suppress (ZERO_HW),
        .o_onehot        (w_wr_onehot)
    );

    // Per-port hazards: a same-cycle write forwards its data, otherwise a busy target stalls
    always_comb begin
        w_rd_hit  = '0;
        w_rd_zero = '0;
        w_bypass  = '0;
        w_stall   = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_rd_hit[p]  = i_rd_en[p] & i_wr_en & (w_rd_id[p] == i_wr_id);
            w_rd_zero[p] = ZERO_HW & (w_rd_id[p] == ZERO_ID);
            w_bypass[p]  = w_rd_hit[p] & ~w_rd_zero[p];
            // Uses the pre-edge scoreboard, so a reservation made this cycle never stalls this read
            w_stall[p]   = i_rd_en[p] & r_busy[w_rd_id[p]] & ~w_rd_hit[p] & ~w_rd_zero[p];
        end
    end

    assign w_rsv_zero = ZERO_HW & (i_rsv_id == ZERO_ID);

    // Scoreboard next state: clear on write commit, then set on reservation so a same-id set wins
    always_comb begin
        w_busy_next = r_busy;
        if (i_wr_en) begin
            w_busy_next[i_wr_id] = 1'b0;
        end
        if (i_rsv_en && !w_rsv_zero) begin
            w_busy_next[i_rsv_id] = 1'b1;
        end
    end

    // Register every output and the scoreboard; reset discards anything in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_wordline <= '0;
            r_wr_wordline <= '0;
            r_rd_bypass   <= '0;
            r_rd_stall    <= '0;
            r_busy        <= '0;
        end else begin
            r_rd_wordline <= w_rd_onehot;
            r_wr_wordline <= w_wr_onehot;
            r_rd_bypass   <= w_bypass;
            r_rd_stall    <= w_stall;
            r_busy        <= w_busy_next;
        end
    end

    assign o_rd_wordline = r_rd_wordline;
    assign o_wr_wordline = r_wr_wordline;
    assign o_rd_bypass   = r_rd_bypass;
    assign o_rd_stall    = r_rd_stall;
    assign o_busy_vec    = r_busy;

endmodule

// File: doc/regfile_port_decoder.md
Name: regfile_port_decoder

Overview:
- Parametrised, registered address decoder for the register file.
- Serves NUM_RD read ports and one write port.
- Generates one-hot wordlines and keeps a per-register busy scoreboard for in-flight writes.
- Flags write-to-read bypass and busy-register stalls per read port; sits between operand decode and the register array.

Parameters:
ADDR_W, 4, register id width
DEPTH, 16, number of registers (must equal 2**ADDR_W)
NUM_RD, 2, number of read ports

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
rd_en  input  NUM_RD  read request per port
rd_id  input  NUM_RD*ADDR_W  read register id; port p occupies bits [p*ADDR_W +: ADDR_W]
wr_en  input  1  write commit this cycle
wr_id  input  ADDR_W  write register id
rsv_en  input  1  reserve destination (mark busy)
rsv_id  input  ADDR_W  register to reserve
rd_wordline  output  NUM_RD*DEPTH  one-hot read wordline; port p at [p*DEPTH +: DEPTH]
wr_wordline  output  DEPTH  one-hot write wordline
rd_bypass  output  NUM_RD  read hits same-cycle write; forward write data
rd_stall  output  NUM_RD  read targets busy register with no same-cycle write
busy_vec  output  DEPTH  scoreboard state

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; busy register cleared. Any operation in flight is discarded.
- Decode latency:
  - All wordline, bypass and stall outputs are registered, one cycle after the inputs are sampled.
  - No combinational input-to-output path.
- rd_wordline[p]:
  - bit rd_id[p] set when rd_en[p]=1; all-zero otherwise.
  - Ports are fully independent; two ports reading the same id both assert that bit.
- wr_wordline: bit wr_id set when wr_en=1, else 0.
- Register 0 (when REG_ZERO_HARDWIRE_EN is defined):
  - rd/wr wordlines for id 0 are all-zero.
  - rsv of id 0 is ignored, so busy_vec[0] stays 0.
  - rd_bypass and rd_stall for id 0 are always 0.
- Scoreboard (busy_q, DEPTH bits), updated at each clock edge:
  - rsv_en sets busy_q[rsv_id].
  - wr_en clears busy_q[wr_id].
  - Same id, same cycle: the set wins (back-to-back reservation). Different ids: both take effect.
  - busy_vec = busy_q, a direct register output.
- rd_bypass[p]: registered value of (rd_en[p] & wr_en & rd_id[p]==wr_id).
- rd_stall[p]:
  - Registered value of (rd_en[p] & busy_q[rd_id[p]] & ~bypass_cond[p]), evaluated against pre-edge busy_q.
  - A reservation issued in the same cycle does not stall that cycle's read.
- Out-of-range ids are impossible (DEPTH=2**ADDR_W); elaboration check fails if DEPTH != 2**ADDR_W.
- No handshake backpressure: the block accepts a new request every cycle.

Optional Feature:
- Macro REG_ZERO_HARDWIRE_EN.
- Defined: register 0 is a hardwired zero register (rules above).
- Undefined: register 0 is an ordinary register. Its wordlines decode, and it can be reserved, bypassed and stalled like any other.

Decomposition:
- Shared package holds:
  - Default constants: REG_ADDR_W=4, REG_DEPTH=16, REG_NUM_RD=2.
  - Typedef reg_id_t (logic [REG_ADDR_W-1:0]).
  - Constant ZERO_REG_ID=0.
- One natural sub-module: onehot_decoder (ADDR_W -> DEPTH, enable input, zero-id suppression input). It is combinational and instantiated NUM_RD+1 times; registering happens in the parent.
- Scoreboard and hazard logic live in the parent.

Test Plan:
- Reset/basic decode:
  - Assert rst_n low mid-cycle: all outputs 0 immediately.
  - Release, then rd_en=01, rd_id[0]=5: next cycle rd_wordline[0]=16'h0020, port 1 = 0.
- Zero register (macro defined):
  - wr_en=1, wr_id=0, rd_en[0]=1, rd_id[0]=0: wr_wordline=0, rd_wordline[0]=0, rd_bypass=0.
  - Same stimulus with the macro undefined: wr_wordline=16'h0001, rd_bypass[0]=1.
- Scoreboard:
  - rsv_en, rsv_id=7 at cycle n: busy_vec=16'h0080 at n+1.
  - Read of 7 at n+1: rd_stall[0]=1 at n+2.
  - wr_en, wr_id=7 at n+3: busy_vec[7]=0 at n+4.
- Bypass priority: busy_q[9]=1; same cycle rd_id[1]=9 with rd_en[1]=1 and wr_en with wr_id=9. Next cycle rd_bypass[1]=1, rd_stall[1]=0, busy_vec[9]=0.
- Simultaneous set/clear: busy_q[3]=1; rsv_id=3 and wr_id=3 in the same cycle. busy_vec[3] stays 1.
- Parametrisation: ADDR_W=5, DEPTH=32, NUM_RD=3; sweep all ids on all ports. Each port is one-hot at its own slice with 1-cycle latency; two ports on the same id both assert.
